// File: rtl/mycpu_store_unit.sv
// Memory-stage store issuer: builds byte strobe and lane-aligned data for sb/sh/sw/swl/swr
// and runs one SRAM-like write transaction. Optional macro: MYCPU_STORE_ALIGN_CHECK_EN.
module mycpu_store_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_mode,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_rt,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        done_valid,
    input  logic        done_ready,
    output logic        done_ades
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    localparam logic [2:0] MODE_SB  = 3'd0;
    localparam logic [2:0] MODE_SH  = 3'd1;
    localparam logic [2:0] MODE_SW  = 3'd2;
    localparam logic [2:0] MODE_SWL = 3'd3;
    localparam logic [2:0] MODE_SWR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t state, state_nx;
    logic   drop, drop_nx;
    logic   load;
    logic   accept;
    logic   illegal;
    logic   misalign;

    logic [1:0]    a;
    logic [SW-1:0] st_strb;
    logic [DW-1:0] st_wdata;
    logic [1:0]    st_size;
    logic [AW-1:0] st_addr;

    logic [SW-1:0] wstrb_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;

    assign a      = in_addr[1:0];
    assign accept = in_valid & in_ready & ~flush;

    // Store formatting: strobe, lane-aligned data, size and bus address
    always_comb begin
        st_strb  = '0;
        st_wdata = '0;
        st_size  = 2'd0;
        st_addr  = '0;
        illegal  = 1'b0;
        case (in_mode)
            MODE_SB: begin
                st_strb  = SW'(4'b0001 << a);
                st_wdata = {4{in_rt[7:0]}};
                st_size  = 2'd0;
                st_addr  = in_addr;
            end
            MODE_SH: begin
                st_strb  = SW'(4'b0011 << {a[1], 1'b0});
                st_wdata = {2{in_rt[15:0]}};
                st_size  = 2'd1;
                st_addr  = {in_addr[31:1], 1'b0};
            end
            MODE_SW: begin
                st_strb  = 4'b1111;
                st_wdata = in_rt;
                st_size  = 2'd2;
                st_addr  = {in_addr[31:2], 2'b00};
            end
            MODE_SWL: begin
                st_size = 2'd2;
                st_addr = {in_addr[31:2], 2'b00};
                case (a)
                    2'd0: begin st_strb = 4'b0001; st_wdata = {24'b0, in_rt[31:24]}; end
                    2'd1: begin st_strb = 4'b0011; st_wdata = {16'b0, in_rt[31:16]}; end
                    2'd2: begin st_strb = 4'b0111; st_wdata = {8'b0, in_rt[31:8]};   end
                    default: begin st_strb = 4'b1111; st_wdata = in_rt;              end
                endcase
            end
            MODE_SWR: begin
                st_size = 2'd2;
                st_addr = {in_addr[31:2], 2'b00};
                case (a)
                    2'd0: begin st_strb = 4'b1111; st_wdata = in_rt;                 end
                    2'd1: begin st_strb = 4'b1110; st_wdata = {in_rt[23:0], 8'b0};   end
                    2'd2: begin st_strb = 4'b1100; st_wdata = {in_rt[15:0], 16'b0};  end
                    default: begin st_strb = 4'b1000; st_wdata = {in_rt[7:0], 24'b0}; end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef MYCPU_STORE_ALIGN_CHECK_EN
    logic ades_q;

    assign misalign = ((in_mode == MODE_SH) & a[0]) | ((in_mode == MODE_SW) & (|a));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     ades_q <= 1'b0;
        else if (accept) ades_q <= misalign;
    end
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nx;
            drop  <= drop_nx;
        end
    end

    // Next-state logic; drop remembers a flush that arrived after the address phase
    always_comb begin
        state_nx = state;
        drop_nx  = drop;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                drop_nx = 1'b0;
                if (accept) begin
                    if (illegal | misalign) begin
                        state_nx = S_ERR;
                    end else begin
                        state_nx = S_REQ;
                        load     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_nx = flush ? S_IDLE : S_DONE;
                    end else begin
                        state_nx = S_WAIT;
                        drop_nx  = flush;
                    end
                end else if (flush) begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_nx = (drop | flush) ? S_IDLE : S_DONE;
                    drop_nx  = 1'b0;
                end else if (flush) begin
                    drop_nx = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                if (done_ready | flush) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready   = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        done_valid = 1'b0;
        done_ades  = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_REQ: begin
                data_req = 1'b1;
                data_wr  = 1'b1;
            end
            S_DONE: done_valid = 1'b1;
            S_ERR: begin
                done_valid = 1'b1;
`ifdef MYCPU_STORE_ALIGN_CHECK_EN
                done_ades  = ades_q;
`endif
            end
            default: ;
        endcase
    end

    // Bus fields captured at acceptance, held stable through the transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstrb_q <= '0;
            wdata_q <= '0;
            size_q  <= 2'd0;
            addr_q  <= '0;
        end else if (load) begin
            wstrb_q <= st_strb;
            wdata_q <= st_wdata;
            size_q  <= st_size;
            addr_q  <= st_addr;
        end
    end

    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;

endmodule

// File: tb/tb_mycpu_store_unit.sv
// Scoreboard bench for mycpu_store_unit: driver pushes expected bus writes and completions,
// negedge monitors pop and compare.
module tb_mycpu_store_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  size;
    } bus_t;

    logic        clk, resetn;
    logic        in_valid, in_ready;
    logic [2:0]  in_mode;
    logic [31:0] in_addr, in_rt;
    logic        flush;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        done_valid, done_ready, done_ades;

    int checks = 0;
    int errors = 0;
    bus_t q_bus[$];
    bit   q_done[$];

    mycpu_store_unit dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_addr(in_addr), .in_rt(in_rt), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .done_valid(done_valid), .done_ready(done_ready), .done_ades(done_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: store semantics expressed as byte-lane arithmetic
    function automatic void model(input logic [2:0] m, input logic [31:0] ad, input logic [31:0] rt,
                                  output bit err, output bit ades, output bus_t b);
        int a;
        a    = int'(ad[1:0]);
        err  = 1'b0;
        ades = 1'b0;
        b    = '0;
        case (m)
            3'd0: begin
                b.strb = 4'(1 << a);
                b.wdata = {24'b0, rt[7:0]} * 32'h0101_0101;
                b.size = 2'd0;
                b.addr = ad;
            end
            3'd1: begin
`ifdef MYCPU_STORE_ALIGN_CHECK_EN
                if (a % 2 != 0) begin err = 1'b1; ades = 1'b1; end
`endif
                b.strb = 4'(3 << (a - a % 2));
                b.wdata = {16'b0, rt[15:0]} * 32'h0001_0001;
                b.size = 2'd1;
                b.addr = ad - 32'(ad % 2);
            end
            3'd2: begin
`ifdef MYCPU_STORE_ALIGN_CHECK_EN
                if (a != 0) begin err = 1'b1; ades = 1'b1; end
`endif
                b.strb = 4'hF;
                b.wdata = rt;
                b.size = 2'd2;
                b.addr = ad - 32'(ad % 4);
            end
            3'd3: begin
                b.strb = 4'((1 << (a + 1)) - 1);
                b.wdata = rt >> (8 * (3 - a));
                b.size = 2'd2;
                b.addr = ad - 32'(ad % 4);
            end
            3'd4: begin
                b.strb = 4'(15 << a);
                b.wdata = rt << (8 * a);
                b.size = 2'd2;
                b.addr = ad - 32'(ad % 4);
            end
            default: err = 1'b1;
        endcase
    endfunction

    // Bus monitor: an accepted address phase must match the oldest expected write
    always @(negedge clk) begin
        if (resetn && data_req && data_addr_ok) begin
            if (q_bus.size() == 0) begin
                chk("bus_unexpected", 32'(data_req), 32'd0);
            end else begin
                bus_t e;
                e = q_bus.pop_front();
                chk("bus_addr", data_addr, e.addr);
                chk("bus_wdata", data_wdata, e.wdata);
                chk("bus_wstrb", 32'(data_wstrb), 32'(e.strb));
                chk("bus_size", 32'(data_size), 32'(e.size));
                chk("bus_wr", 32'(data_wr), 32'd1);
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (resetn && done_valid && done_ready) begin
            if (q_done.size() == 0) begin
                chk("done_unexpected", 32'(done_valid), 32'd0);
            end else begin
                bit e;
                e = q_done.pop_front();
                chk("done_ades", 32'(done_ades), 32'(e));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_req"}, 32'(data_req), 32'd0);
        chk({tag, "_wr"}, 32'(data_wr), 32'd0);
        chk({tag, "_done"}, 32'(done_valid), 32'd0);
        chk({tag, "_ades"}, 32'(done_ades), 32'd0);
        chk({tag, "_size"}, 32'(data_size), 32'd0);
        chk({tag, "_addr"}, data_addr, 32'd0);
        chk({tag, "_wdata"}, data_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(data_wstrb), 32'd0);
    endtask

    task automatic finish_done(input bit ades, input int d3, input int f);
        if (f == 3) begin
            flush = 1'b1;
            tick;
            flush = 1'b0;
            chk("flush_done_idle", 32'(in_ready), 32'd1);
            chk("flush_done_novalid", 32'(done_valid), 32'd0);
            return;
        end
        for (int i = 0; i < d3; i++) begin
            chk("hold_valid", 32'(done_valid), 32'd1);
            chk("hold_ades", 32'(done_ades), 32'(ades));
            chk("hold_busy", 32'(in_ready), 32'd0);
            tick;
        end
        q_done.push_back(ades);
        done_ready = 1'b1;
        tick;
        done_ready = 1'b0;
        chk("done_release", 32'(in_ready), 32'd1);
    endtask

    // f: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in DONE/ERR
    task automatic run(input logic [2:0] m, input logic [31:0] ad, input logic [31:0] rt,
                       input int d1_in, input int d2, input int d3, input int f);
        bit   err, ades;
        bus_t b;
        int   n, d1;
        d1 = d1_in;
        model(m, ad, rt, err, ades, b);
        n = 0;
        while (!in_ready && n < 20) begin tick; n++; end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_mode = m; in_addr = ad; in_rt = rt;
        tick;
        in_valid = 1'b0; in_mode = 3'($urandom); in_addr = $urandom; in_rt = $urandom;
        if (err) begin
            chk("err_noreq", 32'(data_req), 32'd0);
            chk("err_valid", 32'(done_valid), 32'd1);
            finish_done(ades, d3, f);
            return;
        end
        q_bus.push_back(b);
        chk("req_latency", 32'(data_req), 32'd1);
        if (f == 1 && d1 == 0) d1 = 1;
        for (int i = 0; i < d1; i++) begin
            if (f == 1 && i == d1 - 1) flush = 1'b1;
            tick;
        end
        if (f == 1) begin
            flush = 1'b0;
            void'(q_bus.pop_back());
            chk("flush_req_idle", 32'(in_ready), 32'd1);
            chk("flush_req_noreq", 32'(data_req), 32'd0);
            chk("flush_req_nodone", 32'(done_valid), 32'd0);
            return;
        end
        data_addr_ok = 1'b1;
        data_data_ok = (d2 == 0 && f != 2);
        tick;
        data_addr_ok = 1'b0;
        if (!data_data_ok) begin
            if (f == 2) begin
                flush = 1'b1;
                tick;
                flush = 1'b0;
                for (int i = 0; i < d2; i++) begin
                    chk("flush_wait_noreq", 32'(data_req), 32'd0);
                    chk("flush_wait_busy", 32'(in_ready), 32'd0);
                    tick;
                end
                data_data_ok = 1'b1;
                tick;
                data_data_ok = 1'b0;
                chk("flush_wait_idle", 32'(in_ready), 32'd1);
                chk("flush_wait_nodone", 32'(done_valid), 32'd0);
                return;
            end
            for (int i = 1; i < d2; i++) tick;
            data_data_ok = 1'b1;
            tick;
        end
        data_data_ok = 1'b0;
        chk("done_latency", 32'(done_valid), 32'd1);
        finish_done(1'b0, d3, f);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_mode = '0; in_addr = '0; in_rt = '0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; done_ready = 1'b0;
        #12;
        check_reset_vals("reset");
        tick;
        resetn = 1'b1;
        tick;

        run(3'd2, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1, 0, 0);
        run(3'd0, 32'h2000_0002, 32'h0000_00A5, 0, 1, 1, 0);
        run(3'd1, 32'h2000_0002, 32'h0000_1234, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run(3'd3, 32'h3000_0000 + 32'(i), 32'h1122_3344, 0, 1, 0, 0);
            run(3'd4, 32'h3000_0000 + 32'(i), 32'h1122_3344, 0, 1, 0, 0);
        end
        run(3'd2, 32'h4000_0001, 32'hCAFE_F00D, 0, 1, 2, 0);
        run(3'd1, 32'h4000_0003, 32'hCAFE_F00D, 0, 1, 1, 0);
        run(3'd5, 32'h5000_0000, 32'h1, 0, 0, 1, 0);
        run(3'd7, 32'h5000_0000, 32'h1, 0, 0, 0, 3);
        run(3'd2, 32'h6000_0000, 32'h5555_AAAA, 3, 0, 0, 1);
        run(3'd2, 32'h6000_0008, 32'h5555_AAAA, 0, 2, 0, 2);
        run(3'd0, 32'h6000_0003, 32'h0000_0077, 0, 1, 4, 0);
        run(3'd4, 32'h6000_0001, 32'h0102_0304, 2, 0, 0, 3);

        // Acceptance blocked by flush in IDLE
        in_valid = 1'b1; in_mode = 3'd2; in_addr = 32'h7000_0000; flush = 1'b1;
        tick;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ready", 32'(in_ready), 32'd1);
        chk("idle_flush_noreq", 32'(data_req), 32'd0);
        tick;

        for (int k = 0; k < 300; k++) begin
            logic [2:0] m;
            int f;
            m = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            f = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            run(m, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), f);
        end

        // Asynchronous reset while waiting for data_data_ok
        run(3'd2, 32'h8000_0000, 32'h1234_5678, 0, 0, 0, 0);
        in_valid = 1'b1; in_mode = 3'd2; in_addr = 32'h8000_0010; in_rt = 32'h8765_4321;
        tick;
        in_valid = 1'b0;
        q_bus.push_back('{addr: 32'h8000_0010, wdata: 32'h8765_4321, strb: 4'hF, size: 2'd2});
        data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0;
        chk("wait_busy", 32'(in_ready), 32'd0);
        #2 resetn = 1'b0;
        #1 check_reset_vals("async_reset");
        tick;
        resetn = 1'b1;
        tick;
        run(3'd0, 32'h9000_0001, 32'h0000_00C3, 0, 1, 0, 0);

        tick;
        chk("bus_queue_empty", 32'(q_bus.size()), 32'd0);
        chk("done_queue_empty", 32'(q_done.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
